// File: rtl/pwm_led_bank_if.sv
// pwm_led_bank_if: configuration write port of the PWM LED bank.
//   CFG_VALID  master->slave  write request
//   CFG_READY  slave->master  write accepted when VALID & READY
//   CFG_CH     master->slave  target channel index (CH_W bits)
//   CFG_MODE   master->slave  00 OFF, 01 STATIC, 10 BREATHE, 11 BLINK
//   CFG_LEVEL  master->slave  static level / breathe peak / blink on-level
// CH_W must equal max(1, clog2(CHANNELS)) of the attached bank, and PWM_BITS
// must match the bank's PWM_BITS.
interface pwm_led_bank_if #(
  parameter int CH_W     = 2,
  parameter int PWM_BITS = 4
) ();
  logic                CFG_VALID;
  logic                CFG_READY;
  logic [CH_W-1:0]     CFG_CH;
  logic [1:0]          CFG_MODE;
  logic [PWM_BITS-1:0] CFG_LEVEL;

  modport master (output CFG_VALID, CFG_CH, CFG_MODE, CFG_LEVEL, input CFG_READY);
  modport slave  (input CFG_VALID, CFG_CH, CFG_MODE, CFG_LEVEL, output CFG_READY);
endinterface

// File: rtl/pwm_led_bank.sv
// pwm_led_bank: N-channel PWM LED driver with per-channel mode/level,
// switch debouncing and frame-aligned (glitch-free) duty updates.
//   CLK          system clock
//   RST          synchronous reset, active-high
//   SW           raw asynchronous switches, bit i gates channel i
//   cfg          config write port (slave side of pwm_led_bank_if)
//   LED_OUT      registered PWM outputs, active-high
//   FRAME_START  one-cycle pulse in the cycle the PWM phase becomes 0
module pwm_led_bank #(
  parameter int CHANNELS     = 4,
  parameter int PWM_BITS     = 4,
  parameter int PRESCALE     = 4096,
  parameter int RAMP_FRAMES  = 4,
  parameter int BLINK_FRAMES = 61,
  parameter int DEBOUNCE_CYC = 16000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] SW,
  pwm_led_bank_if.slave       cfg,
  output logic [CHANNELS-1:0] LED_OUT,
  output logic                FRAME_START
);
  localparam int CH_W    = (CHANNELS > 1)     ? $clog2(CHANNELS)     : 1;
  localparam int PS_W    = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int RAMP_W  = (RAMP_FRAMES > 1)  ? $clog2(RAMP_FRAMES)  : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  logic [PS_W-1:0]     presc_reg;
  logic [PWM_BITS-1:0] phase_reg;
  logic                frame_start_reg;
  logic                ready_reg;
  logic                tick;
  logic                frame_wrap;
  logic                cfg_fire;

  assign tick       = (presc_reg == PS_W'(PRESCALE - 1));
  // Edge on which the phase returns to 0: every channel's effective level is
  // updated on this same edge, so the new duty holds for the whole frame.
  assign frame_wrap = tick && (phase_reg == '1);
  assign cfg_fire   = cfg.CFG_VALID && ready_reg;

  assign cfg.CFG_READY = ready_reg;
  assign FRAME_START   = frame_start_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg       <= '0;
      phase_reg       <= '0;
      frame_start_reg <= 1'b0;
      ready_reg       <= 1'b0;
    end else begin
      ready_reg       <= 1'b1;
      frame_start_reg <= frame_wrap;
      if (tick) begin
        presc_reg <= '0;
        phase_reg <= phase_reg + 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    mode_e               pend_mode_reg;
    logic [PWM_BITS-1:0] pend_level_reg;
    mode_e               act_mode_reg, act_mode_next;
    logic [PWM_BITS-1:0] e_reg, e_next;
    logic                dir_down_reg, dir_down_next;
    logic [RAMP_W-1:0]   ramp_cnt_reg, ramp_cnt_next;
    logic                blink_off_reg, blink_off_next;
    logic [BLINK_W-1:0]  blink_cnt_reg, blink_cnt_next;
    logic [1:0]          sync_reg;
    logic                db_reg;
    logic [DB_W-1:0]     db_cnt_reg;
    logic                led_reg;
    logic                wr_hit;
    logic                entering;
    logic                ramp_step;

    // Out-of-range channel indices match no channel, so such writes are
    // accepted and silently dropped.
    assign wr_hit    = cfg_fire && (cfg.CFG_CH == CH_W'(gi));
    assign entering  = (pend_mode_reg != act_mode_reg);
    assign ramp_step = (ramp_cnt_reg == RAMP_W'(RAMP_FRAMES - 1));

    always_ff @(posedge CLK) begin
      if (RST) begin
        pend_mode_reg  <= MODE_OFF;
        pend_level_reg <= '0;
      end else if (wr_hit) begin
        pend_mode_reg  <= mode_e'(cfg.CFG_MODE);
        pend_level_reg <= cfg.CFG_LEVEL;
      end
    end

    always_comb begin
      act_mode_next  = act_mode_reg;
      e_next         = e_reg;
      dir_down_next  = dir_down_reg;
      ramp_cnt_next  = ramp_cnt_reg;
      blink_off_next = blink_off_reg;
      blink_cnt_next = blink_cnt_reg;
      if (frame_wrap) begin
        act_mode_next = pend_mode_reg;
        unique case (pend_mode_reg)
          MODE_OFF:    e_next = '0;
          MODE_STATIC: e_next = pend_level_reg;
          MODE_BREATHE: begin
            if (entering) begin
              e_next        = '0;
              dir_down_next = 1'b0;
              ramp_cnt_next = '0;
            end else begin
              ramp_cnt_next = ramp_step ? '0 : ramp_cnt_reg + 1'b1;
              if (pend_level_reg == '0) begin
                e_next        = '0;
                dir_down_next = 1'b0;
              end else if (ramp_step) begin
                // Reverse at the peak (or above it, if the peak was lowered)
                // and at zero; each reversal also takes the step.
                if (!dir_down_reg) begin
                  if (e_reg >= pend_level_reg) begin
                    e_next        = e_reg - 1'b1;
                    dir_down_next = 1'b1;
                  end else begin
                    e_next = e_reg + 1'b1;
                  end
                end else begin
                  if (e_reg == '0) begin
                    e_next        = e_reg + 1'b1;
                    dir_down_next = 1'b0;
                  end else begin
                    e_next = e_reg - 1'b1;
                  end
                end
              end
            end
          end
          MODE_BLINK: begin
            if (entering) begin
              blink_cnt_next = '0;
              blink_off_next = 1'b0;
            end else if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
              blink_cnt_next = '0;
              blink_off_next = !blink_off_reg;
            end else begin
              blink_cnt_next = blink_cnt_reg + 1'b1;
            end
            e_next = blink_off_next ? '0 : pend_level_reg;
          end
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        act_mode_reg  <= MODE_OFF;
        e_reg         <= '0;
        dir_down_reg  <= 1'b0;
        ramp_cnt_reg  <= '0;
        blink_off_reg <= 1'b0;
        blink_cnt_reg <= '0;
      end else begin
        act_mode_reg  <= act_mode_next;
        e_reg         <= e_next;
        dir_down_reg  <= dir_down_next;
        ramp_cnt_reg  <= ramp_cnt_next;
        blink_off_reg <= blink_off_next;
        blink_cnt_reg <= blink_cnt_next;
      end
    end

    // Two-flop synchroniser, then a stability counter: a change is accepted
    // only after DEBOUNCE_CYC consecutive cycles of disagreement.
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_reg   <= '0;
        db_reg     <= 1'b0;
        db_cnt_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[0], SW[gi]};
        if (sync_reg[1] == db_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_reg     <= sync_reg[1];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        led_reg <= 1'b0;
      end else begin
        led_reg <= (e_reg > phase_reg) && db_reg;
      end
    end

    assign LED_OUT[gi] = led_reg;
  end
endmodule

// File: tb/tb_pwm_led_bank.sv
// tb_pwm_led_bank: directed self-checking bench for pwm_led_bank.
// A second, 3-channel instance exercises writes to an out-of-range channel.
module tb_pwm_led_bank;
  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_STATIC  = 2'd1;
  localparam logic [1:0] M_BREATHE = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] SW  = 4'hF;
  logic [3:0] LED_OUT;
  logic       FRAME_START;
  logic [2:0] led3;
  logic       fs3;

  int tests_run    = 0;
  int tests_failed = 0;
  int cnt[4];
  int cnt3[3];
  int n;
  int breathe_exp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int blink_exp[6]   = '{8, 8, 0, 0, 8, 8};

  pwm_led_bank_if #(.CH_W(2), .PWM_BITS(4)) cfg_if ();
  pwm_led_bank_if #(.CH_W(2), .PWM_BITS(4)) cfg3_if ();

  pwm_led_bank #(
    .CHANNELS(4), .PWM_BITS(4), .PRESCALE(2),
    .RAMP_FRAMES(1), .BLINK_FRAMES(2), .DEBOUNCE_CYC(4)
  ) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .cfg(cfg_if),
    .LED_OUT(LED_OUT), .FRAME_START(FRAME_START)
  );

  pwm_led_bank #(
    .CHANNELS(3), .PWM_BITS(4), .PRESCALE(2),
    .RAMP_FRAMES(1), .BLINK_FRAMES(2), .DEBOUNCE_CYC(4)
  ) dut3 (
    .CLK(CLK), .RST(RST), .SW(SW[2:0]), .cfg(cfg3_if),
    .LED_OUT(led3), .FRAME_START(fs3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 3; i++) cnt3[i] = 0;
  endtask

  task automatic count_cycles(input int cycles);
    repeat (cycles) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) cnt[i] += int'(LED_OUT[i]);
      for (int i = 0; i < 3; i++) cnt3[i] += int'(led3[i]);
    end
  endtask

  // Called at the negedge of a FRAME_START cycle; covers exactly one frame
  // of LED output and ends on the next FRAME_START cycle.
  task automatic frame_duty(input string what);
    clear_counts();
    count_cycles(32);
    $display("[TB] frame %s: led cycles %0d %0d %0d %0d", what, cnt[0], cnt[1], cnt[2], cnt[3]);
  endtask

  task automatic sync_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!FRAME_START && cycles < 200);
    check("frame_start_seen", int'(FRAME_START), 1);
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_if.CFG_VALID = 1'b1;
    cfg_if.CFG_CH    = ch;
    cfg_if.CFG_MODE  = mode;
    cfg_if.CFG_LEVEL = lvl;
    check("cfg_ready", int'(cfg_if.CFG_READY), 1);
    $display("[TB] cfg write ch=%0d mode=%0d level=%0d", ch, mode, lvl);
    @(posedge CLK);
    #1 cfg_if.CFG_VALID = 1'b0;
  endtask

  task automatic write_cfg3(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg3_if.CFG_VALID = 1'b1;
    cfg3_if.CFG_CH    = ch;
    cfg3_if.CFG_MODE  = mode;
    cfg3_if.CFG_LEVEL = lvl;
    check("cfg3_ready", int'(cfg3_if.CFG_READY), 1);
    $display("[TB] cfg3 write ch=%0d mode=%0d level=%0d", ch, mode, lvl);
    @(posedge CLK);
    #1 cfg3_if.CFG_VALID = 1'b0;
  endtask

  initial begin
    cfg_if.CFG_VALID  = 1'b0;
    cfg_if.CFG_CH     = '0;
    cfg_if.CFG_MODE   = M_OFF;
    cfg_if.CFG_LEVEL  = '0;
    cfg3_if.CFG_VALID = 1'b0;
    cfg3_if.CFG_CH    = '0;
    cfg3_if.CFG_MODE  = M_OFF;
    cfg3_if.CFG_LEVEL = '0;

    // Reset and timebase
    repeat (3) @(negedge CLK);
    check("rst_led", int'(LED_OUT), 0);
    check("rst_ready", int'(cfg_if.CFG_READY), 0);
    check("rst_fs", int'(FRAME_START), 0);
    RST = 1'b0;
    sync_frame(n);
    check("first_fs_latency", n, 32);
    check("ready_after_rst", int'(cfg_if.CFG_READY), 1);
    sync_frame(n);
    check("fs_period", n, 32);

    // STATIC levels; a write in the FRAME_START cycle waits one frame
    write_cfg(2'd0, M_STATIC, 4'd5);
    frame_duty("static5_pending");
    check("static5_pending_ch0", cnt[0], 0);
    frame_duty("static5");
    check("static5_ch0", cnt[0], 10);
    check("static5_ch1", cnt[1], 0);
    check("static5_ch2", cnt[2], 0);
    check("static5_ch3", cnt[3], 0);
    write_cfg(2'd0, M_STATIC, 4'd15);
    frame_duty("static15_pending");
    check("fs_write_delayed_ch0", cnt[0], 10);
    frame_duty("static15");
    check("static15_ch0", cnt[0], 30);

    // Mid-frame write must not disturb the running frame
    write_cfg(2'd1, M_STATIC, 4'd3);
    frame_duty("ch1_pending");
    frame_duty("ch1_lvl3");
    check("ch1_lvl3", cnt[1], 6);
    clear_counts();
    count_cycles(10);
    write_cfg(2'd1, M_STATIC, 4'd12);
    count_cycles(22);
    $display("[TB] frame midwrite: led cycles %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
    check("mid_frame_hold_ch1", cnt[1], 6);
    check("mid_frame_fs_aligned", int'(FRAME_START), 1);
    frame_duty("ch1_lvl12");
    check("ch1_lvl12", cnt[1], 24);

    // BREATHE triangle, then peak 0
    write_cfg(2'd2, M_BREATHE, 4'd3);
    frame_duty("breathe_pending");
    for (int k = 0; k < 8; k++) begin
      frame_duty("breathe");
      check($sformatf("breathe_f%0d", k), cnt[2], 2 * breathe_exp[k]);
    end
    write_cfg(2'd2, M_BREATHE, 4'd0);
    frame_duty("breathe0_pending");
    frame_duty("breathe0_a");
    check("breathe_lvl0_a", cnt[2], 0);
    frame_duty("breathe0_b");
    check("breathe_lvl0_b", cnt[2], 0);

    // BLINK
    write_cfg(2'd3, M_BLINK, 4'd8);
    frame_duty("blink_pending");
    for (int k = 0; k < 6; k++) begin
      frame_duty("blink");
      check($sformatf("blink_f%0d", k), cnt[3], 2 * blink_exp[k]);
    end

    // Out-of-range channel on the 3-channel instance is dropped
    write_cfg3(2'd3, M_STATIC, 4'd15);
    frame_duty("oor_pending");
    frame_duty("oor");
    check("oor_ch0", cnt3[0], 0);
    check("oor_ch1", cnt3[1], 0);
    check("oor_ch2", cnt3[2], 0);
    write_cfg3(2'd1, M_STATIC, 4'd6);
    frame_duty("inrange_pending");
    frame_duty("inrange");
    check("inrange_ch1", cnt3[1], 12);
    check("inrange_ch0", cnt3[0], 0);

    // Debounce: 3-cycle glitch ignored, 4-cycle glitch passes through
    clear_counts();
    fork
      count_cycles(32);
      begin
        repeat (5) @(negedge CLK);
        SW[0] = 1'b0;
        repeat (3) @(negedge CLK);
        SW[0] = 1'b1;
      end
    join
    $display("[TB] frame glitch3: led cycles %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
    check("glitch3_ignored", cnt[0], 30);
    clear_counts();
    fork
      count_cycles(32);
      begin
        repeat (5) @(negedge CLK);
        SW[0] = 1'b0;
        repeat (4) @(negedge CLK);
        SW[0] = 1'b1;
      end
    join
    $display("[TB] frame glitch4: led cycles %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
    check("glitch4_accepted", cnt[0], 26);
    SW[0] = 1'b0;
    frame_duty("sw0_falling");
    frame_duty("sw0_low");
    check("sw0_low_ch0", cnt[0], 0);
    check("sw0_low_ch1", cnt[1], 24);
    SW[0] = 1'b1;
    frame_duty("sw0_rising");
    frame_duty("sw0_high");
    check("sw0_high_ch0", cnt[0], 30);

    // Reset in the middle of a breathing frame
    write_cfg(2'd2, M_BREATHE, 4'd3);
    frame_duty("pre_reset_a");
    frame_duty("pre_reset_b");
    count_cycles(9);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_led", int'(LED_OUT), 0);
    check("midrst_fs", int'(FRAME_START), 0);
    check("midrst_ready", int'(cfg_if.CFG_READY), 0);
    @(negedge CLK);
    RST = 1'b0;
    sync_frame(n);
    check("post_rst_fs_latency", n, 32);
    frame_duty("post_reset");
    check("post_rst_ch0", cnt[0], 0);
    check("post_rst_ch2", cnt[2], 0);
    check("post_rst_ch1", cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
